// File: rtl/decode_pkg.sv
// decode_pkg: RV32I opcode classes, immediate selects and the 24-bit control word
package decode_pkg;
  localparam logic [4:0] OP_R      = 5'b01100;
  localparam logic [4:0] OP_R32    = 5'b01110;
  localparam logic [4:0] OP_IMM    = 5'b00100;
  localparam logic [4:0] OP_IMM32  = 5'b00110;
  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_sel_e;
  typedef struct packed {
    logic [3:0] alu_op;
    imm_sel_e   imm_sel;
    logic       alu_src_a;
    logic       alu_src_b;
    logic       reg_we;
    logic       mem_re;
    logic       mem_we;
    logic [2:0] mem_size;
    logic       branch;
    logic       jump;
    logic       jalr;
    logic       is_m;
    logic       illegal;
    logic       use_rs1;
    logic       use_rs2;
    logic [1:0] rsvd;
  } ctrl_t;
endpackage

// File: rtl/inst_decoder.sv
// inst_decoder: combinational RV32I(+M) decode into a control word and sign-extended immediate
module inst_decoder
  import decode_pkg::*;
#(
  parameter bit EN_M = 1'b0,
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst_i,
  output ctrl_t           ctrl_o,
  output logic [XLEN-1:0] imm_o
);
  logic [4:0] op;
  logic [2:0] f3;
  logic [6:0] f7;
  logic mul, bad;
  ctrl_t c;
  logic signed [31:0] imm;
  assign op  = inst_i[6:2];
  assign f3  = inst_i[14:12];
  assign f7  = inst_i[31:25];
  assign mul = op == OP_R && f7 == 7'b0000001;
  always_comb begin
    c = '0;
    c.use_rs1 = 1'b1;
    bad = inst_i[1:0] != 2'b11;
    case (op)
      OP_R, OP_R32: begin
        c.alu_op = {f7[5] & ~mul, f3};
        c.reg_we = 1'b1;
        c.use_rs2 = 1'b1;
        c.is_m = mul;
        bad = bad | (mul & ~EN_M);
      end
      OP_IMM, OP_IMM32: begin
        c.imm_sel = IMM_I;
        c.alu_op = {(f3 == 3'b101) & f7[5], f3};
        c.alu_src_b = 1'b1;
        c.reg_we = 1'b1;
      end
      OP_LOAD: begin
        c.imm_sel = IMM_I;
        c.alu_src_b = 1'b1;
        c.reg_we = 1'b1;
        c.mem_re = 1'b1;
        c.mem_size = f3;
      end
      OP_STORE: begin
        c.imm_sel = IMM_S;
        c.alu_src_b = 1'b1;
        c.mem_we = 1'b1;
        c.mem_size = f3;
        c.use_rs2 = 1'b1;
      end
      OP_BRANCH: begin
        c.imm_sel = IMM_B;
        c.alu_op = {1'b0, f3};
        c.branch = 1'b1;
        c.use_rs2 = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        c.imm_sel = IMM_U;
        c.alu_src_a = op == OP_AUIPC;
        c.alu_src_b = 1'b1;
        c.reg_we = 1'b1;
        c.use_rs1 = 1'b0;
      end
      OP_JAL: begin
        c.imm_sel = IMM_J;
        c.alu_src_a = 1'b1;
        c.jump = 1'b1;
        c.reg_we = 1'b1;
        c.use_rs1 = 1'b0;
      end
      OP_JALR: begin
        c.imm_sel = IMM_I;
        c.alu_src_b = 1'b1;
        c.jump = 1'b1;
        c.jalr = 1'b1;
        c.reg_we = 1'b1;
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      c = '0;
      c.illegal = 1'b1;
    end
  end
  // jalr keeps the I-format immediate even though it is grouped with the jumps
  assign imm = c.imm_sel == IMM_I ? {{20{inst_i[31]}}, inst_i[31:20]} :
               c.imm_sel == IMM_S ? {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]} :
               c.imm_sel == IMM_B ? {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0} :
               c.imm_sel == IMM_U ? {inst_i[31:12], 12'b0} :
               c.imm_sel == IMM_J ? {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0} :
               '0;
  assign imm_o  = XLEN'(imm);
  assign ctrl_o = c;
endmodule

// File: rtl/decode_queue.sv
// decode_queue: registered RV32I decode stage feeding an in-order valid/ready queue
module decode_queue
  import decode_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter bit EN_M  = 1'b0,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output ctrl_t           out_ctrl,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [31:0]     dec_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  ctrl_t dec_ctrl;
  logic [XLEN-1:0] dec_imm;
  ctrl_t ctrl_q [DEPTH];
  logic [XLEN-1:0] imm_q [DEPTH];
  logic [XLEN-1:0] pc_q [DEPTH];
  logic [14:0] regs_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d, cnt_q, cnt_d;
  logic [31:0] pops_q, pops_d;
  logic push, pop;
  inst_decoder #(.EN_M(EN_M), .XLEN(XLEN)) u_dec (
    .inst_i(in_inst),
    .ctrl_o(dec_ctrl),
    .imm_o (dec_imm)
  );
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign in_ready  = cnt_q != PW'(DEPTH);
  assign out_valid = cnt_q != '0;
  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready & ~flush;
  always_comb begin
    wr_d   = flush ? '0 : push ? nxt(wr_q) : wr_q;
    rd_d   = flush ? '0 : pop ? nxt(rd_q) : rd_q;
    cnt_d  = flush ? '0 : cnt_q + PW'(push) - PW'(pop);
    pops_d = pops_q + 32'(pop);
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      pops_q <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      pops_q <= pops_d;
    end
  end
  // storage is deliberately left out of reset; occupancy alone qualifies it
  always_ff @(posedge clk) begin
    if (push) begin
      ctrl_q[wr_q[AW-1:0]] <= dec_ctrl;
      imm_q[wr_q[AW-1:0]]  <= dec_imm;
      pc_q[wr_q[AW-1:0]]   <= in_pc;
      regs_q[wr_q[AW-1:0]] <= {in_inst[19:15], in_inst[24:20], in_inst[11:7]};
    end
  end
  assign out_ctrl  = ctrl_q[rd_q[AW-1:0]];
  assign out_imm   = imm_q[rd_q[AW-1:0]];
  assign out_pc    = pc_q[rd_q[AW-1:0]];
  assign {out_rs1, out_rs2, out_rd} = regs_q[rd_q[AW-1:0]];
  assign dec_count = pops_q;
endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue: scoreboard bench driving two queues (EN_M=0 and EN_M=1) with identical traffic
module tb_decode_queue;
  import decode_pkg::*;
  localparam int DEPTH = 2;
  localparam logic [4:0] OPS [11] = '{5'b01100, 5'b01110, 5'b00100, 5'b00110, 5'b00000, 5'b01000,
                                      5'b11000, 5'b01101, 5'b00101, 5'b11011, 5'b11001};
  typedef struct packed {logic [31:0] pc; logic [31:0] inst;} ent_t;
  typedef struct packed {logic ill; logic rs1; logic rs2; logic ism; logic [31:0] imm;} exp_t;
  logic clk = 0, rstn = 0, in_valid = 0, flush = 0, out_ready = 0;
  logic [31:0] in_inst = 0, in_pc = 0;
  logic in_ready [2];
  logic out_valid [2];
  ctrl_t out_ctrl [2];
  logic [31:0] out_imm [2], out_pc [2], dec_count [2];
  logic [4:0] out_rs1 [2], out_rs2 [2], out_rd [2];
  int vectors = 0, miscompares = 0, exp_pops = 0;
  ent_t sb [$];
  exp_t e;
  for (genvar g = 0; g < 2; g++) begin : g_dut
    decode_queue #(.DEPTH(DEPTH), .EN_M(g == 1), .XLEN(32)) dut (
      .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready[g]), .in_inst(in_inst),
      .in_pc(in_pc), .flush(flush), .out_valid(out_valid[g]), .out_ready(out_ready),
      .out_ctrl(out_ctrl[g]), .out_imm(out_imm[g]), .out_pc(out_pc[g]), .out_rs1(out_rs1[g]),
      .out_rs2(out_rs2[g]), .out_rd(out_rd[g]), .dec_count(dec_count[g])
    );
  end
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // reference decode straight from the ISA tables
  function automatic exp_t model(input logic [31:0] i, input bit em);
    exp_t r = '0;
    logic [4:0] op = i[6:2];
    bit mul = op == 5'b01100 && i[31:25] == 7'b0000001;
    r.ill = i[1:0] != 2'b11 || !(op inside {OPS}) || (mul && !em);
    if (r.ill) return r;
    r.ism = mul;
    r.rs1 = !(op inside {5'b01101, 5'b00101, 5'b11011});
    r.rs2 = op inside {5'b01100, 5'b01110, 5'b01000, 5'b11000};
    case (op)
      5'b00100, 5'b00110, 5'b00000, 5'b11001: r.imm = 32'($signed(i[31:20]));
      5'b01000: r.imm = 32'($signed({i[31:25], i[11:7]}));
      5'b11000: r.imm = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
      5'b01101, 5'b00101: r.imm = {i[31:12], 12'b0};
      5'b11011: r.imm = 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
      default: r.imm = 0;
    endcase
    return r;
  endfunction
  function automatic logic [31:0] rnd_inst();
    logic [31:0] i = $urandom;
    int s = $urandom_range(0, 13);
    if (s < 11) i[6:2] = OPS[s];
    if ($urandom_range(0, 9) != 0) i[1:0] = 2'b11;
    if ($urandom_range(0, 3) == 0) i[31:25] = 7'b0000001;
    return i;
  endfunction
  task automatic step(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                      input logic ordy, input logic fl);
    bit acc;
    in_valid = v; in_inst = inst; in_pc = pc; out_ready = ordy; flush = fl;
    acc = v && !fl && sb.size() < DEPTH;
    @(posedge clk);
    if (fl) sb.delete();
    else if (acc) sb.push_back(ent_t'{pc, inst});
    #1;
  endtask
  // monitor: compares the head against the scoreboard and retires it on a handshake
  always @(negedge clk) if (rstn) begin
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("dut%0d.out_valid", d), out_valid[d], sb.size() != 0);
      chk($sformatf("dut%0d.in_ready", d), in_ready[d], sb.size() != DEPTH);
      chk($sformatf("dut%0d.dec_count", d), dec_count[d], exp_pops);
      if (sb.size() != 0 && out_valid[d]) begin
        e = model(sb[0].inst, d == 1);
        chk($sformatf("dut%0d.pc", d), out_pc[d], sb[0].pc);
        chk($sformatf("dut%0d.imm", d), out_imm[d], e.imm);
        chk($sformatf("dut%0d.illegal", d), out_ctrl[d].illegal, e.ill);
        chk($sformatf("dut%0d.is_m", d), out_ctrl[d].is_m, e.ism);
        chk($sformatf("dut%0d.use_rs1", d), out_ctrl[d].use_rs1, e.rs1);
        chk($sformatf("dut%0d.use_rs2", d), out_ctrl[d].use_rs2, e.rs2);
        chk($sformatf("dut%0d.regs", d), {out_rs1[d], out_rs2[d], out_rd[d]},
            {sb[0].inst[19:15], sb[0].inst[24:20], sb[0].inst[11:7]});
      end
    end
    if (sb.size() != 0 && out_ready && !flush) begin
      void'(sb.pop_front());
      exp_pops++;
    end
  end
  initial begin
    repeat (3) @(posedge clk);
    #1 rstn = 1;
    chk("reset.out_valid", out_valid[0], 1'b0);
    chk("reset.in_ready", in_ready[0], 1'b1);
    chk("reset.dec_count", dec_count[0], 0);
    step(1, 32'hFFF00093, 32'h100, 1, 0);
    chk("addi.valid", out_valid[0], 1'b1);
    chk("addi.imm", out_imm[0], 32'hFFFF_FFFF);
    chk("addi.rd", out_rd[0], 5'd1);
    chk("addi.pc", out_pc[0], 32'h100);
    chk("addi.use", {out_ctrl[0].use_rs1, out_ctrl[0].use_rs2}, 2'b10);
    step(0, 0, 0, 1, 0);
    chk("addi.dec_count", dec_count[0], 1);
    for (int k = 0; k < DEPTH; k++) step(1, rnd_inst(), 32'h200 + 4 * k, 0, 0);
    chk("full.in_ready", in_ready[0], 1'b0);
    step(1, rnd_inst(), 32'h2F0, 0, 0);
    step(0, 0, 0, 1, 0);
    chk("drain.in_ready", in_ready[0], 1'b1);
    repeat (3) step(0, 0, 0, 1, 0);
    for (int k = 0; k < DEPTH; k++) step(1, rnd_inst(), 32'h300 + 4 * k, 0, 0);
    for (int k = 0; k < 10; k++) step(1, rnd_inst(), 32'h400 + 4 * k, 1, 0);
    step(0, 0, 0, 0, 0);
    step(1, rnd_inst(), 32'h500, 0, 1);
    chk("flush.out_valid", out_valid[0], 1'b0);
    chk("flush.in_ready", in_ready[0], 1'b1);
    step(1, 32'h02208033, 32'h600, 1, 0);
    chk("mul.illegal0", out_ctrl[0].illegal, 1'b1);
    chk("mul.illegal1", out_ctrl[1].illegal, 1'b0);
    chk("mul.is_m1", out_ctrl[1].is_m, 1'b1);
    step(1, 32'h0000007F, 32'h604, 1, 0);
    chk("op7f.illegal", out_ctrl[0].illegal, 1'b1);
    step(0, 0, 0, 1, 0);
    for (int k = 0; k < 400; k++)
      step($urandom_range(0, 3) != 0, rnd_inst(), $urandom, $urandom_range(0, 2) != 0,
           $urandom_range(0, 29) == 0);
    for (int k = 0; k < DEPTH; k++) step(1, rnd_inst(), 32'h700 + 4 * k, 0, 0);
    #2 rstn = 0;
    #1;
    chk("areset.out_valid", out_valid[0], 1'b0);
    chk("areset.in_ready", in_ready[0], 1'b1);
    chk("areset.dec_count", dec_count[0], 0);
    sb.delete();
    exp_pops = 0;
    in_valid = 0;
    repeat (2) @(posedge clk);
    #1 rstn = 1;
    step(1, 32'h00500113, 32'h800, 0, 0);
    step(1, 32'h004000EF, 32'h804, 1, 0);
    repeat (3) step(0, 0, 0, 1, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
